// File: rtl/audio_pkg.sv
// Shared constants for the song-player audio output path.
// Sample width, PWM step count, midscale code and the underrun counter ceiling,
// plus the one-step-toward-midscale helper used by the soft-mute path.
package audio_pkg;

    localparam int                  SAMPLE_W     = 4;
    localparam int                  PWM_STEPS    = 16;
    localparam logic [SAMPLE_W-1:0] MIDSCALE     = 4'd8;
    localparam logic [7:0]          UNDERRUN_MAX = 8'd255;

    // Move a duty code one step toward midscale; holds once it is there.
    function automatic logic [SAMPLE_W-1:0] mute_step(input logic [SAMPLE_W-1:0] cur);
        logic [SAMPLE_W-1:0] nxt;
        nxt = cur;
        if (cur < MIDSCALE) begin
            nxt = cur + 4'd1;
        end else if (cur > MIDSCALE) begin
            nxt = cur - 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample stream from the song ROM reader into the PWM output stage.
//
// Handshake: a transfer happens on a rising clock edge where sample_valid and
// sample_ready are both high. Once the master raises sample_valid it holds
// sample_valid and sample_data stable until that transfer edge; sample_ready
// may rise or fall in any cycle and never depends on sample_valid.
interface audio_pwm_out_if;
    import audio_pkg::*;

    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO for the audio sample stream.
// Wrap-around pointers carry one extra bit so full and empty are distinguished
// without a separate counter. The flush input empties the FIFO on the next edge.
module sample_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk_s,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update: reset and flush both return the FIFO to empty.
    always_ff @(posedge clk_s) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk_s) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/audio_pwm_out.sv
// Single-pin PWM audio output stage for the song player.
// A FIFO absorbs samples; each 16-step PWM frame plays one sample, loaded at the
// frame-end cycle. With play low the output drifts or jumps to midscale.
// Optional feature macro: AUDIO_PWM_SOFT_MUTE_EN (ramp toward midscale one code
// per frame instead of jumping there).
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int FRAME_DIV  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk50Mghz,
    input  logic                          reset_n,
    input  logic                          play,
    audio_pwm_out_if.slave                smp,
    output logic                          pwm_out,
    output logic [SAMPLE_W-1:0]           level,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    underrun_cnt
);

    localparam int                  DIV_W     = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(FRAME_DIV - 1);
    localparam int                  STEP_W    = $clog2(PWM_STEPS);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(PWM_STEPS - 1);

    logic [DIV_W-1:0]    div;
    logic [STEP_W-1:0]   step;
    logic                frame_end;
    logic                push;
    logic                pop;
    logic                flush;
    logic                fifo_full;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [SAMPLE_W-1:0] level_nxt;
    logic [7:0]          ucnt_nxt;

    // Ready is held low during reset so nothing is accepted while registers clear.
    assign smp.sample_ready = reset_n && play && !fifo_full;
    assign push      = smp.sample_valid && smp.sample_ready;
    assign frame_end = (step == STEP_LAST) && (div == DIV_LAST);
    // No bypass: a pop only sees what was already stored before this edge.
    assign pop       = frame_end && play && !fifo_empty;
    assign flush     = !play;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_s (clk50Mghz),
        .rst_n (reset_n),
        .flush (flush),
        .push  (push),
        .din   (smp.sample_data),
        .pop   (pop),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Step timing: div runs 0..FRAME_DIV-1, step advances on each div wrap.
    always_ff @(posedge clk50Mghz) begin
        if (!reset_n) begin
            div  <= '0;
            step <= '0;
        end else if (div == DIV_LAST) begin
            div  <= '0;
            step <= step + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Frame-end loader: next duty code and underrun accounting.
    always_comb begin
        level_nxt = level;
        ucnt_nxt  = underrun_cnt;
        if (frame_end) begin
            if (play) begin
                if (!fifo_empty) begin
                    level_nxt = fifo_head;
                end else if (underrun_cnt != UNDERRUN_MAX) begin
                    ucnt_nxt = underrun_cnt + 8'd1;
                end
            end else begin
`ifdef AUDIO_PWM_SOFT_MUTE_EN
                level_nxt = mute_step(level);
`else
                level_nxt = MIDSCALE;
`endif
            end
        end
    end

    // Level, underrun counter and the registered duty compare.
    always_ff @(posedge clk50Mghz) begin
        if (!reset_n) begin
            level        <= MIDSCALE;
            underrun_cnt <= '0;
            pwm_out      <= 1'b0;
        end else begin
            level        <= level_nxt;
            underrun_cnt <= ucnt_nxt;
            pwm_out      <= (step < level);
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out (default FRAME_DIV=12, FIFO_DEPTH=4).
// Honours AUDIO_PWM_SOFT_MUTE_EN in its expectations when defined.
module tb_audio_pwm_out;

    localparam int FRAME_DIV = 12;
    localparam int FRAME     = 16 * FRAME_DIV;
    localparam int DEPTH     = 4;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic       play;
    logic       pwm_out;
    logic [3:0] level;
    logic [2:0] fifo_count;
    logic [7:0] underrun_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    audio_pwm_out_if smp_if ();

    audio_pwm_out #(
        .FRAME_DIV  (FRAME_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk50Mghz    (clk),
        .reset_n      (reset_n),
        .play         (play),
        .smp          (smp_if),
        .pwm_out      (pwm_out),
        .level        (level),
        .fifo_count   (fifo_count),
        .underrun_cnt (underrun_cnt)
    );

    // ---------------- reference model ----------------
    // Frame position comes from a plain cycle count since reset release; the
    // FIFO is a queue of accepted samples.
    logic [3:0] exp_q[$];
    logic [3:0] m_level;
    logic [7:0] m_ucnt;
    logic       m_pwm;
    int         m_cyc;
    int         m_pos;
    bit         m_acc;

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            m_level = 4'd8;
            m_ucnt  = 8'd0;
            m_pwm   = 1'b0;
            m_cyc   = 0;
        end else begin
            m_pos = m_cyc % FRAME;
            m_acc = play && smp_if.sample_valid && (exp_q.size() < DEPTH);
            m_pwm = ((m_pos / FRAME_DIV) < int'(m_level));
            if (m_pos == FRAME - 1) begin
                if (play) begin
                    if (exp_q.size() > 0) m_level = exp_q.pop_front();
                    else if (m_ucnt < 8'd255) m_ucnt = m_ucnt + 8'd1;
                end else begin
`ifdef AUDIO_PWM_SOFT_MUTE_EN
                    if (m_level < 4'd8) m_level = m_level + 4'd1;
                    else if (m_level > 4'd8) m_level = m_level - 4'd1;
`else
                    m_level = 4'd8;
`endif
                end
            end
            if (!play) exp_q.delete();
            else if (m_acc) exp_q.push_back(smp_if.sample_data);
            m_cyc = m_cyc + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        smp_if.sample_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Advance (at negedges) until the model has seen c edges since reset release.
    task automatic wait_cyc(input int c);
        while (m_cyc < c) @(negedge clk);
    endtask

    // Offer one sample and hold it until accepted; returns on the negedge after the transfer.
    task automatic send(input logic [3:0] d);
        bit ok;
        ok = 1'b0;
        smp_if.sample_data  = d;
        smp_if.sample_valid = 1'b1;
        #1;
        for (int i = 0; i < 2000; i++) begin
            if (smp_if.sample_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        smp_if.sample_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got=not_accepted exp=accepted data=%0d", d);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        play = 1'b1;
        do_reset(2);
        send(4'd3);
        wait_cyc(FRAME + 20);
        send(4'd11);
        send(4'd6);
        wait_cyc(FRAME + 60);
        checks++;
        if (level !== 4'd3) begin failures++; $display("FAIL pre_reset_level got=%0d exp=3", level); end
        checks++;
        if (fifo_count !== 3'd2) begin failures++; $display("FAIL pre_reset_count got=%0d exp=2", fifo_count); end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (level !== 4'd8) begin failures++; $display("FAIL reset_level got=%0d exp=8", level); end
            checks++;
            if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
            checks++;
            if (pwm_out !== 1'b0) begin failures++; $display("FAIL reset_pwm got=%0b exp=0", pwm_out); end
            checks++;
            if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL reset_ucnt got=%0d exp=0", underrun_cnt); end
            checks++;
            if (smp_if.sample_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", smp_if.sample_ready); end
        end
        reset_n = 1'b1;
        // Start-up alignment and frame-end latency with a fresh sample.
        send(4'd7);
        wait_cyc(FRAME - 1);
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL startup_before_end got=%0d exp=8", level); end
        wait_cyc(FRAME);
        checks++;
        if (level !== 4'd7) begin failures++; $display("FAIL startup_load got=%0d exp=7", level); end
        checks++;
        if (pwm_out !== 1'b0) begin failures++; $display("FAIL startup_pwm_last got=%0b exp=0", pwm_out); end
        wait_cyc(FRAME + 1);
        checks++;
        if (pwm_out !== 1'b1) begin failures++; $display("FAIL startup_pwm_first got=%0b exp=1", pwm_out); end
    endtask

    task automatic test_basic_play();
        logic [3:0] lv [3];
        int hi;
        lv[0] = 4'd5; lv[1] = 4'd15; lv[2] = 4'd0;
        play = 1'b1;
        do_reset(2);
        for (int i = 0; i < 3; i++) send(lv[i]);
        for (int f = 1; f <= 3; f++) begin
            wait_cyc(f * FRAME);
            hi = 0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (pwm_out === 1'b1) hi++;
                if (c == FRAME / 2) begin
                    checks++;
                    if (level !== lv[f-1]) begin failures++; $display("FAIL basic_level frame=%0d got=%0d exp=%0d", f, level, lv[f-1]); end
                end
            end
            checks++;
            if (hi != 12 * int'(lv[f-1])) begin failures++; $display("FAIL basic_pwm_high frame=%0d got=%0d exp=%0d", f, hi, 12 * int'(lv[f-1])); end
        end
        checks++;
        if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL basic_underrun got=%0d exp=1", underrun_cnt); end
    endtask

    task automatic test_full_fifo();
        logic [3:0] sent_q[$];
        logic [3:0] cur;
        logic [3:0] exp_lv;
        bit         pend;
        int         acc_cnt;
        int         exp_acc;
        play = 1'b1;
        do_reset(2);
        cur = 4'($urandom_range(0, 15));
        smp_if.sample_data  = cur;
        smp_if.sample_valid = 1'b1;
        acc_cnt = 0;
        #1;
        pend = smp_if.sample_ready;
        while (m_cyc < 6 * FRAME) begin
            @(negedge clk);
            if (pend) begin
                sent_q.push_back(cur);
                acc_cnt++;
                cur = 4'($urandom_range(0, 15));
                smp_if.sample_data = cur;
            end
            if (m_cyc == DEPTH) begin
                checks++;
                if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
                checks++;
                if (smp_if.sample_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", smp_if.sample_ready); end
            end
            if (m_cyc % FRAME == 0) begin
                exp_acc = (m_cyc == FRAME) ? DEPTH : 1;
                checks++;
                if (acc_cnt != exp_acc) begin failures++; $display("FAIL full_accepts cyc=%0d got=%0d exp=%0d", m_cyc, acc_cnt, exp_acc); end
                acc_cnt = 0;
            end
            if (m_cyc % FRAME == FRAME / 2 && m_cyc > FRAME) begin
                exp_lv = sent_q.pop_front();
                checks++;
                if (level !== exp_lv) begin failures++; $display("FAIL full_order cyc=%0d got=%0d exp=%0d", m_cyc, level, exp_lv); end
            end
            pend = smp_if.sample_ready;
        end
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic test_edge_push();
        logic [3:0] d;
        play = 1'b1;
        do_reset(2);
        d = 4'($urandom_range(0, 7));
        wait_cyc(FRAME - 1);
        smp_if.sample_data  = d;
        smp_if.sample_valid = 1'b1;
        @(negedge clk);
        smp_if.sample_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1) begin failures++; $display("FAIL edge_count got=%0d exp=1", fifo_count); end
        checks++;
        if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL edge_underrun got=%0d exp=1", underrun_cnt); end
        checks++;
        if (level !== 4'd8) begin failures++; $display("FAIL edge_hold got=%0d exp=8", level); end
        wait_cyc(2 * FRAME);
        checks++;
        if (level !== d) begin failures++; $display("FAIL edge_next_frame got=%0d exp=%0d", level, d); end
        checks++;
        if (underrun_cnt !== 8'd1) begin failures++; $display("FAIL edge_underrun_after got=%0d exp=1", underrun_cnt); end
    endtask

    task automatic test_mute();
        int exp_lv;
        play = 1'b1;
        do_reset(2);
        send(4'd13);
        wait_cyc(FRAME + 20);
        send(4'd4);
        send(4'd6);
        wait_cyc(FRAME + FRAME / 2);
        checks++;
        if (level !== 4'd13) begin failures++; $display("FAIL mute_start_level got=%0d exp=13", level); end
        play = 1'b0;
        smp_if.sample_data  = 4'd2;
        smp_if.sample_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0) begin failures++; $display("FAIL mute_flush got=%0d exp=0", fifo_count); end
        checks++;
        if (level !== 4'd13) begin failures++; $display("FAIL mute_midframe got=%0d exp=13", level); end
        for (int k = 1; k <= 6; k++) begin
            wait_cyc((k + 1) * FRAME + FRAME / 2);
`ifdef AUDIO_PWM_SOFT_MUTE_EN
            exp_lv = (13 - k > 8) ? 13 - k : 8;
`else
            exp_lv = 8;
`endif
            checks++;
            if (int'(level) != exp_lv) begin failures++; $display("FAIL mute_level k=%0d got=%0d exp=%0d", k, level, exp_lv); end
            checks++;
            if (smp_if.sample_ready !== 1'b0) begin failures++; $display("FAIL mute_ready k=%0d got=%0b exp=0", k, smp_if.sample_ready); end
            checks++;
            if (fifo_count !== 3'd0) begin failures++; $display("FAIL mute_count k=%0d got=%0d exp=0", k, fifo_count); end
            checks++;
            if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL mute_underrun k=%0d got=%0d exp=0", k, underrun_cnt); end
        end
        smp_if.sample_valid = 1'b0;
        play = 1'b1;
        send(4'd3);
        wait_cyc(8 * FRAME + FRAME / 2);
        checks++;
        if (level !== 4'd3) begin failures++; $display("FAIL mute_resume got=%0d exp=3", level); end
        checks++;
        if (underrun_cnt !== 8'd0) begin failures++; $display("FAIL mute_resume_underrun got=%0d exp=0", underrun_cnt); end
    endtask

    task automatic test_random();
        int  thr;
        bit  pend;
        bit  exp_rdy;
        play = 1'b1;
        do_reset(2);
        thr  = 0;
        pend = 1'b0;
        while (m_cyc < 25 * FRAME) begin
            @(negedge clk);
            exp_rdy = play && (exp_q.size() < DEPTH);
            checks++;
            if (level !== m_level) begin failures++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", m_cyc, level, m_level); end
            checks++;
            if (int'(fifo_count) != exp_q.size()) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", m_cyc, fifo_count, exp_q.size()); end
            checks++;
            if (underrun_cnt !== m_ucnt) begin failures++; $display("FAIL rand_underrun cyc=%0d got=%0d exp=%0d", m_cyc, underrun_cnt, m_ucnt); end
            checks++;
            if (pwm_out !== m_pwm) begin failures++; $display("FAIL rand_pwm cyc=%0d got=%0b exp=%0b", m_cyc, pwm_out, m_pwm); end
            checks++;
            if (smp_if.sample_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", m_cyc, smp_if.sample_ready, exp_rdy); end
            if (m_cyc % FRAME == 0) begin
                case ($urandom_range(0, 3))
                    0: thr = 0;
                    1: thr = 1;
                    2: thr = 3;
                    default: thr = 40;
                endcase
            end
            if ($urandom_range(0, 399) == 0) play = !play;
            if (!smp_if.sample_valid || pend) begin
                smp_if.sample_valid = ($urandom_range(0, 255) < thr);
                smp_if.sample_data  = 4'($urandom_range(0, 15));
            end
            #1;
            pend = smp_if.sample_valid && smp_if.sample_ready;
        end
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic test_underrun();
        int exp_u;
        play = 1'b1;
        do_reset(2);
        send(4'd9);
        for (int f = 1; f <= 301; f++) begin
            wait_cyc(f * FRAME + FRAME / 2);
            exp_u = (f - 1 > 255) ? 255 : f - 1;
            checks++;
            if (level !== 4'd9) begin failures++; $display("FAIL underrun_level frame=%0d got=%0d exp=9", f, level); end
            checks++;
            if (int'(underrun_cnt) != exp_u) begin failures++; $display("FAIL underrun_cnt frame=%0d got=%0d exp=%0d", f, underrun_cnt, exp_u); end
        end
        checks++;
        if (underrun_cnt !== 8'd255) begin failures++; $display("FAIL underrun_saturate got=%0d exp=255", underrun_cnt); end
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        reset_n = 1'b0;
        play    = 1'b0;
        smp_if.sample_valid = 1'b0;
        smp_if.sample_data  = 4'd0;
        test_reset();
        test_basic_play();
        test_full_fifo();
        test_edge_push();
        test_mute();
        test_random();
        test_underrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_pwm_out.md
# audio_pwm_out

Downstream output stage for the song player: consumes the 4-bit sample stream read from the song ROM at the divided sample rate and drives a single-pin PWM audio output. A small FIFO decouples sample arrival from the PWM frame boundary. Each PWM frame plays one sample. An idle/mute path parks the output at midscale.

## Interface
- `FRAME_DIV`, default 12: `clk50Mghz` cycles per PWM step; a frame is 16 steps, i.e. 192 cycles (≈260 kHz carrier).
- `FIFO_DEPTH`, default 4: sample FIFO entries; must be a power of two, ≥2.
- `clk50Mghz`, in, 1: the single clock. All logic runs on its rising edge.
- `reset_n`, in, 1: reset, synchronous, active-low.
- `play`, in, 1: playback enable, level-sensitive.
- `sample_data`, in, 4: unsigned sample, 0..15.
- `sample_valid`, in, 1: `sample_data` is valid this cycle.
- `sample_ready`, out, 1: FIFO accepts a sample this cycle.
- `pwm_out`, out, 1: registered PWM output.
- `level`, out, 4: duty code of the current frame.
- `fifo_count`, out, $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `underrun_cnt`, out, 8: saturating count of frames that started with an empty FIFO while playing.

## Operation
- **Push.** A sample is pushed when `sample_valid && sample_ready`.
  - `sample_ready = play && (fifo_count != FIFO_DEPTH)`.
- **Step timing.** `div` counts 0..FRAME_DIV-1. `step` (4 bits) increments when `div` wraps and wraps 15→0.
  - Frame end: `step==15 && div==FRAME_DIV-1`.
- **Duty compare.** `pwm_out` is registered as `(step < level)`.
  - Level 0 gives constant low.
  - Level 15 gives a 15/16 duty.
- **Frame-end load.** The next `level` is chosen at frame end:
  - `play` high and FIFO non-empty: pop the head; `level` = head.
  - `play` high and FIFO empty: hold `level`; `underrun_cnt` +1, saturating at 255.
  - `play` low: midscale path (see Configuration). The FIFO is flushed to empty on the first cycle `play` is low.
- **Push and pop in the same cycle.** Allowed whenever the FIFO is non-empty and not full; `fifo_count` is unchanged.
  - No bypass: a push into an empty FIFO in the frame-end cycle does not satisfy that pop. The frame counts as an underrun.
- **No backpressure beyond `sample_ready`.** The upstream must hold `sample_valid`/`sample_data` until accepted. A sample offered while not ready is not captured.
- **Counter freeze.** `underrun_cnt` never wraps. It does not increment while `play` is low.

## Timing
- **Reset values:** `pwm_out`=0, `level`=8, `div`=0, `step`=0, FIFO empty, `fifo_count`=0, `underrun_cnt`=0, `sample_ready`=0.
- **Reset mid-operation:** every register returns to its reset value on the next edge. Queued samples are discarded.
- **Start-up:** the first frame after reset starts at `div`=0, `step`=0 on the cycle after `reset_n` rises.
- **Push latency:** a sample accepted at edge N is visible in `fifo_count` after edge N.
- **Frame-end latency:** a `level` loaded at the frame-end edge applies to the compare on the next cycle. `pwm_out` reflects it one further cycle later.
- **`play` changes:** a mid-frame change never alters the frame in progress. It takes effect at the next frame end (apart from the FIFO flush and `sample_ready`).
- **Full FIFO:** `sample_ready` drops in the cycle after the push that filled the FIFO. It rises in the cycle after the pop that frees an entry.

## Configuration
- `AUDIO_PWM_SOFT_MUTE_EN` defined: with `play` low, each frame end moves `level` one step toward 8 (+1 if below, −1 if above, hold at 8).
  - Purpose: avoid clicks.
  - On `play` rising, normal loading resumes at the next frame end.
- `AUDIO_PWM_SOFT_MUTE_EN` undefined: with `play` low, `level` is set to 8 at the next frame end.

## Structure
- **Shared package `audio_pkg`:**
  - `SAMPLE_W` = 4.
  - `PWM_STEPS` = 16.
  - `MIDSCALE` = 4'd8.
  - `UNDERRUN_MAX` = 8'd255.
- **Sub-module `sample_fifo`:** synchronous, parameterised by width and depth.
  - Pointers are wrap-around, with one extra bit for full/empty.
  - Has a synchronous flush input.
- **Top level:** divider/step counters, frame-end loader, soft-mute logic and the `pwm_out` register.

## Test plan
- **Reset:** assert `reset_n`=0 for 3 cycles mid-frame with 2 samples queued → `level`=8, `fifo_count`=0, `pwm_out`=0, `underrun_cnt`=0.
- **Basic play:** `play`=1, push 5, 15, 0 → successive frames show `level` 5, 15, 0.
  - `pwm_out` high for 60, 180 and 0 cycles per 192-cycle frame.
- **Full FIFO:** hold `sample_valid`=1 → `sample_ready` drops at `fifo_count`=4.
  - Exactly one accept per frame thereafter, with no sample lost or duplicated.
- **Underrun:** stop pushing after sample 9 → `level` holds 9 and `underrun_cnt` increments once per frame.
  - Forced to 300 empty frames, the counter saturates at 255.
- **Edge push:** push into an empty FIFO in the frame-end cycle → that frame counts as an underrun; the sample plays in the following frame.
- **Mute:** `play` dropped with `level`=13 → without the macro, `level`=8 after the next frame end.
  - With `AUDIO_PWM_SOFT_MUTE_EN`: 12, 11, 10, 9, 8 over 5 frames; FIFO flushed; `sample_ready`=0.
